// File: rtl/addsub_share_ctrl.sv
// Shares one WIDTH-bit adder-subtractor between two valid/ready requesters.
// A round-robin arbiter picks a requester; the result is returned tagged with its id.
module addsub_share_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic             last_grant_reg;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             sub_reg, id_reg;
  logic             rsp_valid_reg, rsp_id_reg, rsp_cout_reg, rsp_ovf_reg;
  logic [WIDTH-1:0] rsp_sum_reg;

  logic [1:0]       req_valid, req_ready;
  logic             grant_id, accept;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_sub;
  logic [WIDTH-1:0] b_eff, sum_next;
  logic             cout_next, ovf_next;

  assign req_valid = {req1_valid, req0_valid};

  // On a tie the requester that did not win last time is favoured.
  always_comb begin
    grant_id = req1_valid;
    if (req0_valid && req1_valid)
      grant_id = ~last_grant_reg;
  end

  // Ready is gated by rst_n so it reads 0 for the whole time reset is held.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && (state_reg == IDLE) && req_valid[gi]
                             && (grant_id == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign accept     = |req_ready;

  assign sel_a   = grant_id ? req1_a   : req0_a;
  assign sel_b   = grant_id ? req1_b   : req0_b;
  assign sel_sub = grant_id ? req1_sub : req0_sub;

  // Subtract as A + ~B + 1, so cout=1 means no borrow.
  assign b_eff = b_reg ^ {WIDTH{sub_reg}};
  assign {cout_next, sum_next} = {1'b0, a_reg} + {1'b0, b_eff} + (WIDTH + 1)'(sub_reg);
  assign ovf_next = (a_reg[WIDTH-1] == b_eff[WIDTH-1]) && (sum_next[WIDTH-1] != a_reg[WIDTH-1]);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      sub_reg        <= 1'b0;
      id_reg         <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_id_reg     <= 1'b0;
      rsp_sum_reg    <= '0;
      rsp_cout_reg   <= 1'b0;
      rsp_ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && accept) begin
        a_reg          <= sel_a;
        b_reg          <= sel_b;
        sub_reg        <= sel_sub;
        id_reg         <= grant_id;
        last_grant_reg <= grant_id;
      end
      if (state_reg == EXEC) begin
        rsp_sum_reg   <= sum_next;
        rsp_cout_reg  <= cout_next;
        rsp_ovf_reg   <= ovf_next;
        rsp_id_reg    <= id_reg;
        rsp_valid_reg <= 1'b1;
      end
      if (state_reg == RESP && rsp_ready)
        rsp_valid_reg <= 1'b0;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_sum   = rsp_sum_reg;
  assign rsp_cout  = rsp_cout_reg;
  assign rsp_ovf   = rsp_ovf_reg;

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Directed bench for addsub_share_ctrl: arbitration order, latency, hold, async reset
// and a randomized pass checked against an integer arithmetic model.
module tb_addsub_share_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req0_sub;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready, req1_sub;
  logic [3:0] req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_ovf;
  logic [3:0] rsp_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  addsub_share_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout and signed for overflow.
  function automatic logic [5:0] model(input logic [3:0] a, input logic [3:0] b, input bit sub);
    int ua, ub, sa, sb, r, s;
    logic cout, ovf;
    logic [31:0] rv;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    if (sub) begin
      r = ua - ub; cout = (ua >= ub); s = sa - sb;
    end else begin
      r = ua + ub; cout = (r > 15); s = sa + sb;
    end
    ovf = (s > 7) || (s < -8);
    rv = r;
    return {ovf, cout, rv[3:0]};
  endfunction

  // Single operation from one requester, response held for 'hold' cycles before ack.
  task automatic op(input bit id, input logic [3:0] a, input logic [3:0] b, input bit sub,
                    input logic [3:0] es, input bit ec, input bit eo, input int hold);
    bit got;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; end
    #1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (id ? req1_ready : req0_ready) begin got = 1; break; end
      tick();
    end
    check("op_accept", 32'(got), 1);
    tick();
    if (id) begin req1_valid = 0; req1_a = ~a; end else begin req0_valid = 0; req0_a = ~a; end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin got = 1; break; end
      tick();
    end
    check("op_rsp_valid", 32'(got), 1);
    for (int i = 0; i < hold; i++) begin
      check("op_hold_valid", 32'(rsp_valid), 1);
      check("op_hold_sum", 32'(rsp_sum), 32'(es));
      tick();
    end
    check("op_sum", 32'(rsp_sum), 32'(es));
    check("op_cout", 32'(rsp_cout), 32'(ec));
    check("op_ovf", 32'(rsp_ovf), 32'(eo));
    check("op_id", 32'(rsp_id), 32'(id));
    $display("[TB] op id=%0d a=%0d b=%0d sub=%0d -> sum=%0d cout=%0d ovf=%0d", id, a, b, sub, rsp_sum, rsp_cout, rsp_ovf);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("op_rsp_drop", 32'(rsp_valid), 0);
  endtask

  initial begin
    logic [3:0] ra, rb;
    bit         rs, rid;
    logic [5:0] m;

    rst_n = 0; rsp_ready = 0;
    req0_valid = 1; req0_a = 0; req0_b = 0; req0_sub = 0;
    req1_valid = 1; req1_a = 0; req1_b = 0; req1_sub = 0;
    #1;
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_sum", 32'(rsp_sum), 0);
    check("rst_flags", {29'd0, rsp_id, rsp_cout, rsp_ovf}, 0);
    req0_valid = 0; req1_valid = 0;
    tick(); tick();
    rst_n = 1;
    tick();

    // 5+3: latency 2 cycles from accept
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_sub = 0;
    #1;
    check("t1_ready0", 32'(req0_ready), 1);
    check("t1_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 0;
    check("t1_exec_ready", 32'(req0_ready), 0);
    check("t1_exec_valid", 32'(rsp_valid), 0);
    tick();
    check("t1_valid", 32'(rsp_valid), 1);
    check("t1_sum", 32'(rsp_sum), 8);
    check("t1_cout", 32'(rsp_cout), 0);
    check("t1_ovf", 32'(rsp_ovf), 1);
    check("t1_id", 32'(rsp_id), 0);
    $display("[TB] op id=0 a=5 b=3 sub=0 -> sum=%0d", rsp_sum);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check("t1_drop", 32'(rsp_valid), 0);
    check("t1_keep_sum", 32'(rsp_sum), 8);

    op(1, 3, 5, 1, 4'b1110, 0, 0, 0);
    op(1, 7, 7, 1, 4'b0000, 1, 0, 2);

    // Both valid, rsp_ready high: grants alternate 0,1,0,1 starting with req0
    req0_a = 2; req0_b = 1; req0_sub = 0;
    req1_a = 6; req1_b = 2; req1_sub = 1;
    req0_valid = 1; req1_valid = 1; rsp_ready = 1;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k % 3 == 0) begin
        check("t3_ready0", 32'(req0_ready), ((k / 3) % 2 == 0) ? 1 : 0);
        check("t3_ready1", 32'(req1_ready), ((k / 3) % 2 == 1) ? 1 : 0);
      end else begin
        check("t3_ready_idle", {30'd0, req1_ready, req0_ready}, 0);
      end
      if (k % 3 == 2) begin
        check("t3_valid", 32'(rsp_valid), 1);
        check("t3_id", 32'(rsp_id), (k / 3) % 2);
        check("t3_sum", 32'(rsp_sum), ((k / 3) % 2 == 0) ? 3 : 4);
        $display("[TB] op id=%0d sum=%0d (round robin)", rsp_id, rsp_sum);
      end
      if (k == 11) begin req0_valid = 0; req1_valid = 0; end
      tick();
    end
    rsp_ready = 0;

    // Response held under backpressure; pending req1 waits for the ack
    req0_valid = 1; req0_a = 4'b1000; req0_b = 1; req0_sub = 1;
    #1;
    check("t4_ready0", 32'(req0_ready), 1);
    tick();
    req0_valid = 0; req0_a = 0;
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_sub = 0;
    #1;
    check("t4_exec_ready1", 32'(req1_ready), 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(rsp_valid), 1);
      check("t4_hold_sum", 32'(rsp_sum), 4'b0111);
      check("t4_hold_cout", 32'(rsp_cout), 1);
      check("t4_hold_ovf", 32'(rsp_ovf), 1);
      check("t4_hold_ready", {30'd0, req1_ready, req0_ready}, 0);
      tick();
    end
    $display("[TB] op id=0 a=8 b=1 sub=1 -> sum=%0d (held)", rsp_sum);
    rsp_ready = 1;
    #1;
    check("t4_ack_ready1", 32'(req1_ready), 0);
    tick();
    check("t4_idle_ready1", 32'(req1_ready), 1);
    check("t4_drop", 32'(rsp_valid), 0);
    check("t4_keep_sum", 32'(rsp_sum), 4'b0111);
    tick();
    req1_valid = 0;
    tick();
    check("t4_r1_valid", 32'(rsp_valid), 1);
    check("t4_r1_sum", 32'(rsp_sum), 2);
    check("t4_r1_id", 32'(rsp_id), 1);
    $display("[TB] op id=1 a=1 b=1 sub=0 -> sum=%0d", rsp_sum);
    tick();
    rsp_ready = 0;

    // Reset during EXEC discards the op and restores req0 tie priority
    req0_valid = 1; req0_a = 5; req0_b = 3; req0_sub = 0;
    #1;
    check("t5_ready0", 32'(req0_ready), 1);
    tick();
    req0_valid = 0;
    rst_n = 0;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 0);
    check("t5_rst_sum", 32'(rsp_sum), 0);
    req0_valid = 1; req1_valid = 1;
    req1_a = 1; req1_b = 2; req1_sub = 0;
    #1;
    check("t5_rst_ready", {30'd0, req1_ready, req0_ready}, 0);
    rst_n = 1;
    #1;
    check("t5_tie_ready0", 32'(req0_ready), 1);
    check("t5_tie_ready1", 32'(req1_ready), 0);
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    check("t5_valid", 32'(rsp_valid), 1);
    check("t5_id", 32'(rsp_id), 0);
    check("t5_sum", 32'(rsp_sum), 8);
    $display("[TB] op id=0 a=5 b=3 sub=0 -> sum=%0d (after reset)", rsp_sum);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // Randomized operations against the integer model
    for (int n = 0; n < 150; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      rid = 1'($urandom_range(0, 1));
      m = model(ra, rb, rs);
      op(rid, ra, rb, rs, m[3:0], m[4], m[5], int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
